// File: rtl/btn_debounce_pkg.sv
// Shared encodings for the push-button conditioning block and the shift/display datapath.
package btn_debounce_pkg;

  localparam int unsigned CMD_W = 2;

  // Per-channel debounce FSM states.
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_PRESS = 2'd1,
    PRESSED    = 2'd2,
    WAIT_REL   = 2'd3
  } db_state_e;

  // Shift command encodings consumed by the downstream shift register.
  localparam logic [CMD_W-1:0] CMD_RIGHT = 2'd0;
  localparam logic [CMD_W-1:0] CMD_LEFT  = 2'd1;
  localparam logic [CMD_W-1:0] CMD_LOAD  = 2'd2;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, debounce FSM with stability counter,
// registered debounced level and single-cycle press pulse.
module btn_debounce_ch
  import btn_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_BITS        = 20
) (
  input  logic mclk,
  input  logic reset,
  input  logic btn_i,
  output logic level_o,
  output logic pulse_o
);

  // Terminal count: compared before increment so the counter never wraps.
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

  logic                sync1_q, sync2_q;
  db_state_e           state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                level_q, level_d;
  logic                pulse_q, pulse_d;

  // Synchroniser, FSM state, counter and output registers.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  // Next-state logic: a level must be stable for DEBOUNCE_CYCLES to be accepted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d = WAIT_PRESS;
          cnt_d   = '0;
        end
      end
      WAIT_PRESS: begin
        if (!sync2_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          pulse_d = 1'b1;
          level_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_BITS'(1);
        end
      end
      PRESSED: begin
        if (!sync2_q) begin
          state_d = WAIT_REL;
          cnt_d   = '0;
        end
      end
      WAIT_REL: begin
        if (sync2_q) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_BITS'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_o = level_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/btn_debounce.sv
// Push-button conditioning: N_BTN debounced channels plus a prioritised,
// registered shift command (load > left > right). Reset is expected to be
// released synchronously to mclk by the board reset logic.
module btn_debounce
  import btn_debounce_pkg::*;
#(
  parameter int unsigned N_BTN           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_BITS        = 20
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic             cmd_valid,
  output logic [1:0]       cmd
);

  logic             cmd_valid_q, cmd_valid_d;
  logic [CMD_W-1:0] cmd_q, cmd_d;

  // One independent debounce channel per button.
  for (genvar g = 0; g < int'(N_BTN); g++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_BITS       (CNT_BITS)
    ) u_ch (
      .mclk   (mclk),
      .reset  (reset),
      .btn_i  (btn[g]),
      .level_o(btn_level[g]),
      .pulse_o(press_pulse[g])
    );
  end

  // Priority encode: highest pulsing index wins, lower ones are dropped.
  always_comb begin
    cmd_valid_d = |press_pulse;
    cmd_d       = CMD_RIGHT;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      if (press_pulse[i]) cmd_d = CMD_W'(i);
    end
  end

  // Command registers, one cycle behind the press pulses.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      cmd_valid_q <= 1'b0;
      cmd_q       <= CMD_RIGHT;
    end else begin
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd       = cmd_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with a short debounce window (4 cycles).
module tb_btn_debounce;

  localparam int unsigned N_BTN = 3;
  localparam int unsigned DC    = 4;
  localparam int unsigned CB    = 3;

  logic             mclk = 1'b0;
  logic             reset;
  logic [N_BTN-1:0] btn;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] press_pulse;
  logic             cmd_valid;
  logic [1:0]       cmd;

  int checks = 0;
  int errors = 0;

  // Activity monitors accumulated by step().
  int               pulse_cnt;
  int               valid_cnt;
  logic [N_BTN-1:0] level_or;

  btn_debounce #(
    .N_BTN          (N_BTN),
    .DEBOUNCE_CYCLES(DC),
    .CNT_BITS       (CB)
  ) dut (
    .mclk       (mclk),
    .reset      (reset),
    .btn        (btn),
    .btn_level  (btn_level),
    .press_pulse(press_pulse),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_mon();
    pulse_cnt = 0;
    valid_cnt = 0;
    level_or  = '0;
  endtask

  // Advance one edge; outputs are observed 1 ns after the rising edge.
  task automatic step();
    @(posedge mclk);
    #1;
    if (press_pulse != '0) pulse_cnt++;
    if (cmd_valid) valid_cnt++;
    level_or = level_or | btn_level;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1'b1;
    btn   = '0;
    clr_mon();
    steps(3);
    check("rst_level", 32'(btn_level),   32'h0);
    check("rst_pulse", 32'(press_pulse), 32'h0);
    check("rst_valid", 32'(cmd_valid),   32'h0);
    check("rst_cmd",   32'(cmd),         32'h0);
    reset = 1'b0;
    steps(2);
    check("idle_level", 32'(btn_level), 32'h0);

    // Clean press on btn[0]: pulse after edge t0+6, command one cycle later.
    clr_mon();
    btn = 3'b001;
    steps(6);
    check("t2_no_early_pulse", 32'(pulse_cnt), 32'd0);
    step();
    check("t2_pulse", 32'(press_pulse), 32'h1);
    check("t2_level", 32'(btn_level),   32'h1);
    step();
    check("t2_pulse_drop", 32'(press_pulse), 32'h0);
    check("t2_valid",      32'(cmd_valid),   32'h1);
    check("t2_cmd",        32'(cmd),         32'h0);
    step();
    check("t2_valid_drop", 32'(cmd_valid), 32'h0);
    clr_mon();
    steps(10);
    check("t2_hold_no_pulse", 32'(pulse_cnt), 32'd0);
    check("t2_hold_no_cmd",   32'(valid_cnt), 32'd0);
    check("t2_hold_level",    32'(btn_level), 32'h1);
    btn = 3'b000;
    steps(6);
    check("t2_rel_level_held", 32'(btn_level), 32'h1);
    step();
    check("t2_rel_level_low", 32'(btn_level), 32'h0);
    steps(2);

    // Bouncing btn[1]: single pulse 6 edges after the final rise.
    clr_mon();
    btn = 3'b010; step();
    btn = 3'b000; step();
    btn = 3'b010; step();
    btn = 3'b000; step();
    btn = 3'b010;
    steps(6);
    check("t3_no_bounce_pulse", 32'(pulse_cnt), 32'd0);
    step();
    check("t3_pulse", 32'(press_pulse), 32'h2);
    check("t3_level", 32'(btn_level),   32'h2);
    step();
    check("t3_valid", 32'(cmd_valid), 32'h1);
    check("t3_cmd",   32'(cmd),       32'h1);
    steps(6);
    check("t3_single_pulse", 32'(pulse_cnt), 32'd1);
    btn = 3'b000;
    steps(9);
    check("t3_rel_level", 32'(btn_level), 32'h0);

    // 2-cycle glitch on btn[2]: rejected.
    clr_mon();
    btn = 3'b100;
    steps(2);
    btn = 3'b000;
    steps(12);
    check("t4_no_pulse", 32'(pulse_cnt), 32'd0);
    check("t4_no_cmd",   32'(valid_cnt), 32'd0);
    check("t4_no_level", 32'(level_or),  32'h0);

    // All three pressed together: load wins, issued once.
    clr_mon();
    btn = 3'b111;
    steps(6);
    check("t5_no_early_pulse", 32'(pulse_cnt), 32'd0);
    step();
    check("t5_pulse", 32'(press_pulse), 32'h7);
    check("t5_level", 32'(btn_level),   32'h7);
    step();
    check("t5_pulse_drop", 32'(press_pulse), 32'h0);
    check("t5_valid",      32'(cmd_valid),   32'h1);
    check("t5_cmd",        32'(cmd),         32'h2);
    steps(8);
    check("t5_one_cmd",   32'(valid_cnt), 32'd1);
    check("t5_one_pulse", 32'(pulse_cnt), 32'd1);
    btn = 3'b000;
    steps(9);
    check("t5_rel_level", 32'(btn_level), 32'h0);

    // Reset while btn[0] is held and pulsing: async clear, then a full re-debounce.
    btn = 3'b001;
    steps(7);
    check("t6_pre_pulse", 32'(press_pulse), 32'h1);
    reset = 1'b1;
    #1;
    check("t1_async_level", 32'(btn_level),   32'h0);
    check("t1_async_pulse", 32'(press_pulse), 32'h0);
    check("t1_async_valid", 32'(cmd_valid),   32'h0);
    check("t1_async_cmd",   32'(cmd),         32'h0);
    steps(3);
    check("t6_in_reset_level", 32'(btn_level), 32'h0);
    reset = 1'b0;
    clr_mon();
    steps(6);
    check("t6_no_early_pulse", 32'(pulse_cnt), 32'd0);
    step();
    check("t6_pulse", 32'(press_pulse), 32'h1);
    step();
    check("t6_valid", 32'(cmd_valid), 32'h1);
    check("t6_cmd",   32'(cmd),       32'h0);
    steps(8);
    check("t6_single_pulse", 32'(pulse_cnt), 32'd1);
    btn = 3'b000;
    steps(9);
    check("t6_rel_level", 32'(btn_level), 32'h0);
    clr_mon();
    btn = 3'b001;
    steps(7);
    check("t6_repress_pulse", 32'(press_pulse), 32'h1);
    step();
    check("t6_repress_valid", 32'(cmd_valid), 32'h1);
    check("t6_repress_count", 32'(pulse_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
